reg_alu_sequencer: RTL

Multi-cycle controller that owns the register bank and ALU pair. It accepts one three-register instruction (`rx ← ry op rz`) per handshake and sequences the datapath through operand read, execute and write-back. It drives the bank's read/write ports and the ALU's 8-bit opcode, and reports completion with the result. It replaces direct switch-driven wiring of the bank and ALU with a handshake-driven engine that later fetch logic can feed.

---
 rtl/reg_alu_pkg.sv | 51 +++++
 rtl/alu_opc_decode.sv | 14 +
 rtl/reg_alu_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/reg_alu_pkg.sv
// Shared types and constants for the register-bank / ALU sequencer.
// Holds the FSM states, the short and full opcode encodings, and the 3->8 opcode map.
package reg_alu_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_NOR = 3'd3,
        OP_SL  = 3'd4,
        OP_SRA = 3'd5,
        OP_SLT = 3'd6,
        OP_SGT = 3'd7
    } short_opc_t;

    localparam logic [7:0] ALU_ADD = 8'h02;
    localparam logic [7:0] ALU_SUB = 8'h03;
    localparam logic [7:0] ALU_AND = 8'h08;
    localparam logic [7:0] ALU_NOR = 8'h0A;
    localparam logic [7:0] ALU_SL  = 8'h14;
    localparam logic [7:0] ALU_SRA = 8'h11;
    localparam logic [7:0] ALU_SLT = 8'h18;
    localparam logic [7:0] ALU_SGT = 8'h19;

    function automatic logic [7:0] decode_opc(input logic [2:0] opc);
        logic [7:0] full;
        case (short_opc_t'(opc))
            OP_ADD:  full = ALU_ADD;
            OP_SUB:  full = ALU_SUB;
            OP_AND:  full = ALU_AND;
            OP_NOR:  full = ALU_NOR;
            OP_SL:   full = ALU_SL;
            OP_SRA:  full = ALU_SRA;
            OP_SLT:  full = ALU_SLT;
            OP_SGT:  full = ALU_SGT;
            default: full = ALU_ADD;
        endcase
        return full;
    endfunction

endpackage

// File: rtl/alu_opc_decode.sv
// Combinational map from the 3-bit instruction opcode to the 8-bit ALU opcode.
// Shared with the board-level test top so both use one table.
module alu_opc_decode
    import reg_alu_pkg::*;
(
    input  logic [2:0] opc,
    output logic [7:0] alu_opc
);

    always_comb begin
        alu_opc = decode_opc(opc);
    end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Handshake-driven engine running rx <- ry op rz through READ, EXEC and WRITE
// against an external register bank and ALU.
module reg_alu_sequencer
    import reg_alu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rx,
    input  logic [ADDR_W-1:0] in_ry,
    input  logic [ADDR_W-1:0] in_rz,
    input  logic [2:0]        in_opc,
    output logic [ADDR_W-1:0] rb_rd_addr1,
    output logic [ADDR_W-1:0] rb_rd_addr2,
    input  logic [DATA_W-1:0] rb_rd_data1,
    input  logic [DATA_W-1:0] rb_rd_data2,
    output logic              rb_wr_en,
    output logic [ADDR_W-1:0] rb_wr_addr,
    output logic [DATA_W-1:0] rb_wr_data,
    output logic [7:0]        alu_opc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic [15:0]       instr_count
);

    state_t            state;
    logic [ADDR_W-1:0] rx_q;
    logic [2:0]        opc_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] r_q;
    logic              wr_en_q;
    logic [7:0]        opc_dec;
    logic              accept;

    alu_opc_decode u_dec (
        .opc     (opc_q),
        .alu_opc (opc_dec)
    );

    assign accept     = in_valid && in_ready;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rb_wr_data = r_q;
    // Reset asserted during WRITE must stop the bank committing on that same edge.
    assign rb_wr_en   = wr_en_q & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_en_q     <= 1'b0;
            result      <= '0;
            instr_count <= '0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            rx_q        <= '0;
            opc_q       <= '0;
            rb_rd_addr1 <= '0;
            rb_rd_addr2 <= '0;
            rb_wr_addr  <= '0;
            alu_opc     <= ALU_ADD;
        end else begin
            done    <= 1'b0;
            wr_en_q <= 1'b0;
            case (state)
                ST_IDLE, ST_WRITE: begin
                    if (accept) begin
                        rx_q        <= in_rx;
                        opc_q       <= in_opc;
                        rb_rd_addr1 <= in_ry;
                        rb_rd_addr2 <= in_rz;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_READ;
                    end else begin
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    a_q     <= rb_rd_data1;
                    b_q     <= rb_rd_data2;
                    alu_opc <= opc_dec;
                    state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    // R, the write port and the completion outputs all load here so they are valid throughout WRITE.
                    r_q         <= alu_result;
                    result      <= alu_result;
                    rb_wr_addr  <= rx_q;
                    wr_en_q     <= 1'b1;
                    done        <= 1'b1;
                    instr_count <= instr_count + 16'd1;
                    in_ready    <= 1'b1;
                    state       <= ST_WRITE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
